tank_ctrl_gen: RTL and testbench
================================

Name: tank_ctrl_gen

Overview:
- Parametrised next-generation player tank controller for the tank engine.
- Tile-stepped movement against a map supplied on a port, rate-limited movement, fire cooldown with a correct bullet direction, and a lives / explosion / respawn state machine.
- Drives the bullet spawner and packs a 32-bit OAM state word for the sprite renderer.

Parameters:
- INIX, 32, spawn X in pixels; must be a multiple of 2**TILE_LOG2.
- INIY, 32, spawn Y in pixels; must be a multiple of 2**TILE_LOG2.
- PLAYER_INDEX, 0, object type written into tank_state[30:29]; range 0..3.
- TILE_LOG2, 5, log2 of the tile size in pixels; one move step is one tile.
- MAP_W, 16, map width in tiles.
- MAP_H, 16, map height in tiles.
- MOVE_PERIOD, 8, minimum number of cycles between two moves while a direction is held; must be ≥1.
- FIRE_COOLDOWN, 4, number of cycles after a shot during which firing is blocked.
- LIVES, 3, lives loaded at reset; range 1..7.
- EXPLODE_CYCLES, 16, duration of the explosion animation in cycles.
- RESPAWN_CYCLES, 32, delay between the end of the explosion and respawn.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- game_over, input, 1, freeze: every register holds its value and no pulses are issued.
- killed, input, 1, hit by a bullet; sampled only in ALIVE.
- up, down, left, right, input, 1 each, direction requests; priority up > down > left > right.
- fire, input, 1, fire request (level).
- map_bits, input, MAP_W*MAP_H, wall map; tile (x,y) is bit y*MAP_W+x; 1 = wall.
- bullet_fire, output, 1, one-cycle shot pulse.
- bullet_direction, output, 2, tank direction latched at the shot.
- pos_x, output, 10, tank X in pixels.
- pos_y, output, 10, tank Y in pixels.
- lives_left, output, 3, remaining lives.
- active, output, 1, high only in ALIVE.
- tank_state, output, 32, packed as {1'b0, PLAYER_INDEX[1:0], active, pos_x, pos_y, dir, rom_row[2:0], rom_col[2:0]}.

Behaviour:
- Direction encoding: 00 up, 01 down, 10 left, 11 right.
- Reset values:
  - state = ALIVE; pos = (INIX, INIY); dir = 00.
  - lives_left = LIVES; all timers = 0.
  - bullet_fire = 0; bullet_direction = 00; active = 1.
- States:
  - ALIVE: movement and fire enabled.
  - EXPLODE: timer counts EXPLODE_CYCLES.
  - RESPAWN: timer counts RESPAWN_CYCLES.
  - DEAD: terminal until reset.
- Movement (ALIVE only, registered, takes effect next cycle):
  - The highest-priority held direction sets dir immediately, whether or not the move succeeds.
  - When move_timer == 0 and a direction is held, the target tile is the current tile ±1.
  - The move is blocked if the target is outside 0..MAP_W-1 / 0..MAP_H-1, or its map bit is 1.
  - If not blocked, pos changes by ±2**TILE_LOG2.
  - On every attempt, blocked or not, move_timer reloads MOVE_PERIOD-1 and then decrements once per cycle.
  - With no direction held, move_timer is forced to 0, so the next press moves on its first cycle.
- Fire (ALIVE only):
  - When fire == 1 and cooldown == 0:
    - bullet_fire = 1 for exactly one cycle;
    - bullet_direction = dir as registered in that cycle, not the direction being requested in the same cycle;
    - cooldown loads FIRE_COOLDOWN.
  - cooldown decrements toward 0. The next shot is possible FIRE_COOLDOWN+1 cycles after the previous one.
  - A fire request that is held produces a pulse every FIRE_COOLDOWN+1 cycles.
- Kill:
  - killed in ALIVE → EXPLODE next cycle; lives_left decrements; active = 0; movement and fire are suppressed in that cycle.
  - killed outside ALIVE is ignored.
  - If killed and fire arrive in the same cycle, the kill wins and no pulse is issued.
- EXPLODE:
  - rom_row = 001; rom_col = timer[2:0] frame.
  - On expiry: RESPAWN if lives_left > 0, else DEAD.
- RESPAWN:
  - On expiry → ALIVE with pos = (INIX, INIY), dir = 00, cooldown = 0, move_timer = 0.
- rom_row / rom_col:
  - ALIVE: rom_row = 000, rom_col = {1'b0, dir}.
  - RESPAWN and DEAD: rom_row = 000, rom_col = 000, active = 0 (the renderer hides the sprite).
- game_over:
  - Freezes state, pos, dir, lives_left and all timers.
  - bullet_fire is forced to 0.
  - On release, operation resumes from the frozen values.
- reset mid-operation: asynchronous return to the reset values from any state, including DEAD.
- Widths:
  - Tile indices are pos >> TILE_LOG2.
  - Timers are sized $clog2(max+1).
  - No wrap-around is possible, because edge moves are blocked.

Test Plan:
- Empty map, INIX = INIY = 32, hold right 20 cycles, MOVE_PERIOD = 8 → pos_x is 64, 96, 128 at cycles 1, 9, 17; dir = 11.
- Wall bit at tile (1,0), tank at (32,32), hold up → pos_y stays 32 and dir becomes 00. Separately, tank at (0,y) and press left → no move (edge block).
- Hold fire 12 cycles, FIRE_COOLDOWN = 4 → bullet_fire pulses at cycles 0, 5, 10; bullet_direction equals the registered dir at each pulse.
- LIVES = 1, killed pulse → active drops next cycle, lives_left = 0, EXPLODE for 16 cycles, then DEAD; a later killed pulse and fire are ignored.
- LIVES = 3, kill → after 16 + 32 cycles ALIVE at (INIX, INIY), dir 00, lives_left = 2.
- game_over asserted mid-explosion with direction and fire held → no change in any output; after release the explosion finishes with its remaining count. An asynchronous reset pulse in DEAD restores lives_left = 3 immediately.

Source files
------------

// File: rtl/tank_ctrl_gen_if.sv
// rtl/tank_ctrl_gen_if.sv - player tank controller signal bundle
//
// Groups the game-side inputs and renderer/spawner outputs of tank_ctrl_gen.
//   master : the tank controller (reads requests/map, drives shot, position, sprite word)
//   slave  : the game environment (drives requests/map, reads controller outputs)
// Signals:
//   game_over, killed, up, down, left, right, fire : control requests
//   map_bits [MAP_W*MAP_H]  : wall map, tile (x,y) at bit y*MAP_W+x
//   bullet_fire, bullet_direction[2] : shot pulse and its direction
//   pos_x[10], pos_y[10], lives_left[3], active, tank_state[32] : tank status

interface tank_ctrl_gen_if #(
  parameter int MAP_W = 16,
  parameter int MAP_H = 16
);
  logic                     game_over;
  logic                     killed;
  logic                     up;
  logic                     down;
  logic                     left;
  logic                     right;
  logic                     fire;
  logic [MAP_W*MAP_H-1:0]   map_bits;
  logic                     bullet_fire;
  logic [1:0]               bullet_direction;
  logic [9:0]               pos_x;
  logic [9:0]               pos_y;
  logic [2:0]               lives_left;
  logic                     active;
  logic [31:0]              tank_state;

  modport master (
    input  game_over, killed, up, down, left, right, fire, map_bits,
    output bullet_fire, bullet_direction, pos_x, pos_y, lives_left, active, tank_state
  );

  modport slave (
    output game_over, killed, up, down, left, right, fire, map_bits,
    input  bullet_fire, bullet_direction, pos_x, pos_y, lives_left, active, tank_state
  );
endinterface

// File: rtl/tank_ctrl_gen.sv
// rtl/tank_ctrl_gen.sv - tile-stepped player tank controller with lives/explosion/respawn FSM
//
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : tank_ctrl_gen_if.master (requests and map in; shot, position, lives,
//           active flag and packed OAM word out)

module tank_ctrl_gen #(
  parameter int INIX           = 32,
  parameter int INIY           = 32,
  parameter int PLAYER_INDEX   = 0,
  parameter int TILE_LOG2      = 5,
  parameter int MAP_W          = 16,
  parameter int MAP_H          = 16,
  parameter int MOVE_PERIOD    = 8,
  parameter int FIRE_COOLDOWN  = 4,
  parameter int LIVES          = 3,
  parameter int EXPLODE_CYCLES = 16,
  parameter int RESPAWN_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  tank_ctrl_gen_if.master  bus
);

  localparam int MT_W   = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int CD_W   = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam int ST_MAX = (EXPLODE_CYCLES > RESPAWN_CYCLES) ? EXPLODE_CYCLES : RESPAWN_CYCLES;
  localparam int ST_W   = $clog2(ST_MAX + 1);
  localparam int IDX_W  = (MAP_W * MAP_H > 1) ? $clog2(MAP_W * MAP_H) : 1;

  localparam logic [9:0]      STEP       = 10'(2 ** TILE_LOG2);
  localparam logic [9:0]      X0         = 10'(INIX);
  localparam logic [9:0]      Y0         = 10'(INIY);
  localparam logic [MT_W-1:0] MT_RELOAD  = MT_W'(MOVE_PERIOD - 1);
  localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(FIRE_COOLDOWN);
  localparam logic [ST_W-1:0] EXP_LAST   = ST_W'(EXPLODE_CYCLES - 1);
  localparam logic [ST_W-1:0] RSP_LAST   = ST_W'(RESPAWN_CYCLES - 1);
  localparam logic [2:0]      LIVES_INIT = 3'(LIVES);
  localparam logic [1:0]      PIDX       = 2'(PLAYER_INDEX);

  typedef enum logic [1:0] {ALIVE, EXPLODE, RESPAWN, DEAD} state_t;

  state_t          state;
  logic [9:0]      pos_x, pos_y;
  logic [1:0]      dir;
  logic [2:0]      lives;
  logic [MT_W-1:0] move_timer;
  logic [CD_W-1:0] cooldown;
  logic [ST_W-1:0] st_timer;
  logic            bullet_fire;
  logic [1:0]      bullet_dir;
  logic            active;

  // Direction request decode and target-tile wall lookup.
  logic             req;
  logic [1:0]       req_dir;
  int               tile_x, tile_y, tgt_x, tgt_y;
  logic [IDX_W-1:0] map_idx;
  logic             blocked;

  always_comb begin
    req     = 1'b1;
    req_dir = 2'b00;
    if (bus.up)         req_dir = 2'b00;
    else if (bus.down)  req_dir = 2'b01;
    else if (bus.left)  req_dir = 2'b10;
    else if (bus.right) req_dir = 2'b11;
    else                req = 1'b0;

    tile_x = int'(pos_x >> TILE_LOG2);
    tile_y = int'(pos_y >> TILE_LOG2);
    tgt_x  = tile_x;
    tgt_y  = tile_y;
    case (req_dir)
      2'b00:   tgt_y = tile_y - 1;
      2'b01:   tgt_y = tile_y + 1;
      2'b10:   tgt_x = tile_x - 1;
      default: tgt_x = tile_x + 1;
    endcase

    map_idx = IDX_W'(tgt_y * MAP_W + tgt_x);
    // Off-map targets count as walls, so positions can never wrap.
    blocked = 1'b1;
    if (tgt_x >= 0 && tgt_x < MAP_W && tgt_y >= 0 && tgt_y < MAP_H)
      blocked = bus.map_bits[map_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALIVE;
      pos_x       <= X0;
      pos_y       <= Y0;
      dir         <= 2'b00;
      lives       <= LIVES_INIT;
      move_timer  <= '0;
      cooldown    <= '0;
      st_timer    <= '0;
      bullet_fire <= 1'b0;
      bullet_dir  <= 2'b00;
      active      <= 1'b1;
    end else if (bus.game_over) begin
      bullet_fire <= 1'b0;
    end else begin
      bullet_fire <= 1'b0;
      case (state)
        ALIVE: begin
          if (bus.killed) begin
            // Kill takes priority over any move or shot in the same cycle.
            state    <= EXPLODE;
            st_timer <= '0;
            lives    <= lives - 3'd1;
            active   <= 1'b0;
          end else begin
            if (req) begin
              dir <= req_dir;
              if (move_timer == '0) begin
                move_timer <= MT_RELOAD;
                if (!blocked) begin
                  case (req_dir)
                    2'b00:   pos_y <= pos_y - STEP;
                    2'b01:   pos_y <= pos_y + STEP;
                    2'b10:   pos_x <= pos_x - STEP;
                    default: pos_x <= pos_x + STEP;
                  endcase
                end
              end else begin
                move_timer <= move_timer - MT_W'(1);
              end
            end else begin
              move_timer <= '0;
            end
            // The shot uses the direction already registered, not this cycle's request.
            if (bus.fire && cooldown == '0) begin
              bullet_fire <= 1'b1;
              bullet_dir  <= dir;
              cooldown    <= CD_LOAD;
            end else if (cooldown != '0) begin
              cooldown <= cooldown - CD_W'(1);
            end
          end
        end
        EXPLODE: begin
          if (st_timer == EXP_LAST) begin
            st_timer <= '0;
            state    <= (lives != 3'd0) ? RESPAWN : DEAD;
          end else begin
            st_timer <= st_timer + ST_W'(1);
          end
        end
        RESPAWN: begin
          if (st_timer == RSP_LAST) begin
            st_timer   <= '0;
            state      <= ALIVE;
            active     <= 1'b1;
            pos_x      <= X0;
            pos_y      <= Y0;
            dir        <= 2'b00;
            cooldown   <= '0;
            move_timer <= '0;
          end else begin
            st_timer <= st_timer + ST_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sprite ROM selection: explosion frames run off the low timer bits.
  logic [2:0] rom_row, rom_col;

  always_comb begin
    rom_row = 3'b000;
    rom_col = 3'b000;
    case (state)
      ALIVE:   rom_col = {1'b0, dir};
      EXPLODE: begin
        rom_row = 3'b001;
        rom_col = 3'(st_timer);
      end
      default: ;
    endcase
  end

  assign bus.bullet_fire      = bullet_fire;
  assign bus.bullet_direction = bullet_dir;
  assign bus.pos_x            = pos_x;
  assign bus.pos_y            = pos_y;
  assign bus.lives_left       = lives;
  assign bus.active           = active;
  assign bus.tank_state       = {1'b0, PIDX, active, pos_x, pos_y, dir, rom_row, rom_col};

endmodule

// File: tb/tb_tank_ctrl_gen.sv
// tb/tb_tank_ctrl_gen.sv - directed self-checking bench for tank_ctrl_gen

module tb_tank_ctrl_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         game_over, killed, up, down, left, right, fire;
  logic [255:0] map_bits;
  int           checks = 0;
  int           failures = 0;

  tank_ctrl_gen_if #(.MAP_W(16), .MAP_H(16)) bus0 ();
  tank_ctrl_gen_if #(.MAP_W(16), .MAP_H(16)) bus1 ();

  assign bus0.game_over = game_over;
  assign bus0.killed    = killed;
  assign bus0.up        = up;
  assign bus0.down      = down;
  assign bus0.left      = left;
  assign bus0.right     = right;
  assign bus0.fire      = fire;
  assign bus0.map_bits  = map_bits;
  assign bus1.game_over = game_over;
  assign bus1.killed    = killed;
  assign bus1.up        = up;
  assign bus1.down      = down;
  assign bus1.left      = left;
  assign bus1.right     = right;
  assign bus1.fire      = fire;
  assign bus1.map_bits  = map_bits;

  tank_ctrl_gen u_dut (.clk(clk), .reset(reset), .bus(bus0));
  tank_ctrl_gen #(.LIVES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    {game_over, killed, up, down, left, right, fire} = '0;
    map_bits = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (bus0.tank_state !== 32'h1080_2000) begin failures++; $display("FAIL reset_state got=%h exp=%h", bus0.tank_state, 32'h1080_2000); end
    checks++; if (bus0.lives_left !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", bus0.lives_left); end
    checks++; if ({bus0.bullet_fire, bus0.bullet_direction, bus0.active} !== 4'b0001) begin failures++; $display("FAIL reset_fire_active got=%b exp=0001", {bus0.bullet_fire, bus0.bullet_direction, bus0.active}); end
    checks++; if (bus1.lives_left !== 3'd1) begin failures++; $display("FAIL reset_lives1 got=%0d exp=1", bus1.lives_left); end
  endtask

  task automatic test_move;
    logic [9:0] exp_x;
    do_reset;
    right = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      exp_x = (k >= 17) ? 10'd128 : (k >= 9) ? 10'd96 : 10'd64;
      checks++; if (bus0.pos_x !== exp_x) begin failures++; $display("FAIL move_x cyc=%0d got=%0d exp=%0d", k, bus0.pos_x, exp_x); end
    end
    checks++; if (bus0.tank_state[7:0] !== 8'hC3 || bus0.pos_y !== 10'd32) begin failures++; $display("FAIL move_dir got=%h/%0d exp=c3/32", bus0.tank_state[7:0], bus0.pos_y); end
    right = 1'b0;
  endtask

  task automatic test_wall;
    do_reset;
    map_bits[1]  = 1'b1;
    map_bits[18] = 1'b1;
    right = 1'b1; tick(1); right = 1'b0;
    checks++; if (bus0.pos_x !== 10'd32 || bus0.tank_state[7:6] !== 2'b11) begin failures++; $display("FAIL wall_right got=%0d/%b exp=32/11", bus0.pos_x, bus0.tank_state[7:6]); end
    tick(1);
    up = 1'b1; tick(1);
    checks++; if (bus0.pos_y !== 10'd32 || bus0.tank_state[7:6] !== 2'b00) begin failures++; $display("FAIL wall_up got=%0d/%b exp=32/00", bus0.pos_y, bus0.tank_state[7:6]); end
    tick(9);
    checks++; if (bus0.pos_y !== 10'd32) begin failures++; $display("FAIL wall_up_retry got=%0d exp=32", bus0.pos_y); end
    up = 1'b0; map_bits = '0; tick(1);
    left = 1'b1; tick(1); left = 1'b0;
    checks++; if (bus0.pos_x !== 10'd0) begin failures++; $display("FAIL left_move got=%0d exp=0", bus0.pos_x); end
    tick(1);
    left = 1'b1; tick(1); left = 1'b0;
    checks++; if (bus0.pos_x !== 10'd0 || bus0.tank_state[7:6] !== 2'b10) begin failures++; $display("FAIL edge_block got=%0d/%b exp=0/10", bus0.pos_x, bus0.tank_state[7:6]); end
  endtask

  task automatic test_fire;
    logic exp_f;
    do_reset;
    right = 1'b1; tick(1); right = 1'b0;
    up = 1'b1; fire = 1'b1; tick(1); up = 1'b0;
    checks++; if (bus0.bullet_fire !== 1'b1 || bus0.bullet_direction !== 2'b11) begin failures++; $display("FAIL fire_first got=%b/%b exp=1/11", bus0.bullet_fire, bus0.bullet_direction); end
    checks++; if (bus0.tank_state[7:6] !== 2'b00) begin failures++; $display("FAIL fire_dir_update got=%b exp=00", bus0.tank_state[7:6]); end
    for (int k = 2; k <= 12; k++) begin
      tick(1);
      exp_f = (k == 6 || k == 11);
      checks++; if (bus0.bullet_fire !== exp_f) begin failures++; $display("FAIL fire_pulse cyc=%0d got=%b exp=%b", k, bus0.bullet_fire, exp_f); end
      if (k == 6) begin
        checks++; if (bus0.bullet_direction !== 2'b00) begin failures++; $display("FAIL fire_dir2 got=%b exp=00", bus0.bullet_direction); end
      end
    end
    fire = 1'b0;
  endtask

  task automatic test_kill_one;
    logic seen;
    do_reset;
    fire = 1'b1; killed = 1'b1; tick(1); killed = 1'b0;
    checks++; if ({bus1.active, bus1.lives_left, bus1.bullet_fire} !== 5'b0_000_0) begin failures++; $display("FAIL kill1_now got=%b exp=00000", {bus1.active, bus1.lives_left, bus1.bullet_fire}); end
    seen = 1'b0;
    tick(1);
    checks++; if (bus1.tank_state[5:0] !== 6'b001_001) begin failures++; $display("FAIL kill1_frame1 got=%b exp=001001", bus1.tank_state[5:0]); end
    for (int k = 3; k <= 16; k++) begin tick(1); seen |= bus1.bullet_fire; end
    checks++; if (bus1.tank_state[5:0] !== 6'b001_111) begin failures++; $display("FAIL kill1_last_frame got=%b exp=001111", bus1.tank_state[5:0]); end
    tick(1);
    checks++; if (bus1.tank_state[5:0] !== 6'b000_000 || bus1.active !== 1'b0) begin failures++; $display("FAIL kill1_dead got=%b/%b exp=000000/0", bus1.tank_state[5:0], bus1.active); end
    killed = 1'b1; up = 1'b1; tick(1); killed = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(1); seen |= bus1.bullet_fire; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill1_no_shot got=%b exp=0", seen); end
    checks++; if (bus1.lives_left !== 3'd0 || bus1.pos_y !== 10'd32 || bus1.active !== 1'b0) begin failures++; $display("FAIL kill1_ignored got=%0d/%0d/%b exp=0/32/0", bus1.lives_left, bus1.pos_y, bus1.active); end
    up = 1'b0; fire = 1'b0;
  endtask

  task automatic test_respawn;
    do_reset;
    right = 1'b1; tick(1); right = 1'b0;
    killed = 1'b1; tick(1); killed = 1'b0;
    checks++; if (bus0.lives_left !== 3'd2 || bus0.active !== 1'b0) begin failures++; $display("FAIL resp_kill got=%0d/%b exp=2/0", bus0.lives_left, bus0.active); end
    tick(15);
    checks++; if (bus0.tank_state[5:3] !== 3'b001) begin failures++; $display("FAIL resp_explode got=%b exp=001", bus0.tank_state[5:3]); end
    tick(1);
    checks++; if (bus0.tank_state[5:0] !== 6'b0 || bus0.active !== 1'b0) begin failures++; $display("FAIL resp_hidden got=%b/%b exp=000000/0", bus0.tank_state[5:0], bus0.active); end
    tick(31);
    checks++; if (bus0.active !== 1'b0) begin failures++; $display("FAIL resp_early got=%b exp=0", bus0.active); end
    tick(1);
    checks++; if (bus0.tank_state !== 32'h1080_2000 || bus0.lives_left !== 3'd2) begin failures++; $display("FAIL resp_alive got=%h/%0d exp=10802000/2", bus0.tank_state, bus0.lives_left); end
  endtask

  task automatic test_game_over;
    do_reset;
    killed = 1'b1; tick(1); killed = 1'b0;
    tick(4);
    checks++; if (bus0.tank_state !== 32'h0080_200C) begin failures++; $display("FAIL go_pre got=%h exp=0080200c", bus0.tank_state); end
    game_over = 1'b1; up = 1'b1; fire = 1'b1; killed = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      checks++; if (bus0.tank_state !== 32'h0080_200C || bus0.bullet_fire !== 1'b0 || bus0.lives_left !== 3'd2) begin failures++; $display("FAIL go_frozen cyc=%0d got=%h/%b/%0d exp=0080200c/0/2", k, bus0.tank_state, bus0.bullet_fire, bus0.lives_left); end
    end
    game_over = 1'b0; up = 1'b0; fire = 1'b0; killed = 1'b0;
    tick(11);
    checks++; if (bus0.tank_state[5:0] !== 6'b001_111) begin failures++; $display("FAIL go_resume got=%b exp=001111", bus0.tank_state[5:0]); end
    tick(1);
    checks++; if (bus0.tank_state[5:0] !== 6'b0 || bus0.active !== 1'b0) begin failures++; $display("FAIL go_respawn got=%b/%b exp=000000/0", bus0.tank_state[5:0], bus0.active); end
  endtask

  task automatic test_dead_reset;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      killed = 1'b1; tick(1); killed = 1'b0;
      tick(48);
    end
    checks++; if (bus0.lives_left !== 3'd0 || bus0.active !== 1'b0 || bus0.tank_state[5:0] !== 6'b0) begin failures++; $display("FAIL dead_state got=%0d/%b/%b exp=0/0/000000", bus0.lives_left, bus0.active, bus0.tank_state[5:0]); end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (bus0.lives_left !== 3'd3 || bus0.active !== 1'b1 || bus0.pos_x !== 10'd32) begin failures++; $display("FAIL async_reset got=%0d/%b/%0d exp=3/1/32", bus0.lives_left, bus0.active, bus0.pos_x); end
    #2 reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    {game_over, killed, up, down, left, right, fire} = '0;
    map_bits = '0;
    test_reset;
    test_move;
    test_wall;
    test_fire;
    test_kill_one;
    test_respawn;
    test_game_over;
    test_dead_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
